// File: rtl/parse_act_sched.sv
// Parse-action scheduler: walks a packet's action list, issues header segments to a
// sub-parser and assembles returned values into the PHV. Optional macro: PARSE_SKIP_INVALID_EN.
module parse_act_sched #(
  parameter int ACT_NUM      = 8,
  parameter int ACT_WIDTH    = 16,
  parameter int PKT_HDR_LEN  = 1024,
  parameter int SUB_PKTS_LEN = 128
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          hdr_valid,
  output logic                          hdr_ready,
  input  logic [PKT_HDR_LEN-1:0]        pkt_hdr,
  input  logic [ACT_NUM*ACT_WIDTH-1:0]  parse_acts,
  output logic                          sub_act_valid,
  output logic [7:0]                    sub_act,
  output logic [SUB_PKTS_LEN-1:0]       sub_pkts_hdr,
  input  logic                          sub_val_valid,
  input  logic [63:0]                   sub_val,
  input  logic [1:0]                    sub_val_type,
  input  logic [2:0]                    sub_val_seq,
  output logic                          phv_valid,
  input  logic                          phv_ready,
  output logic [895:0]                  phv_out,
  output logic                          act_err
);
  // state | meaning
  // IDLE  | waiting for a header/action offer
  // ISSUE | examining one action per cycle
  // DRAIN | two cycles covering sub-parser latency
  // OUT   | PHV presented until phv_ready
  localparam int NUM_SEG = PKT_HDR_LEN / SUB_PKTS_LEN;
  localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int IDX_W   = (ACT_NUM > 1) ? $clog2(ACT_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;
  state_t r_state, w_next;

  logic [PKT_HDR_LEN-1:0]       r_hdr;
  logic [ACT_NUM*ACT_WIDTH-1:0] r_acts;
  logic                         r_dcnt;
  logic                         r_drop;
  logic [895:0]                 r_phv;
  logic                         r_err;
  logic                         r_sav;
  logic [7:0]                   r_sa;
  logic [SUB_PKTS_LEN-1:0]      r_sph;

  logic [IDX_W-1:0] w_sel;
  logic             w_exam, w_last, w_accept, w_issue, w_bad;
  logic             w_act_v, w_seg_ok;
  logic [4:0]       w_seg;
  logic [7:0]       w_act_lo;

`ifdef PARSE_SKIP_INVALID_EN
  logic [ACT_NUM-1:0] r_pend, w_rest, w_vmask;
  always_comb begin
    w_vmask = '0;
    for (int i = 0; i < ACT_NUM; i++) w_vmask[i] = parse_acts[i*ACT_WIDTH + 15];
    w_rest = r_pend & (r_pend - ACT_NUM'(1));
    w_sel  = '0;
    for (int i = ACT_NUM-1; i >= 0; i--) if (r_pend[i]) w_sel = IDX_W'(i);
    w_exam = |r_pend;
    w_last = (w_rest == '0);
  end
`else
  logic [IDX_W-1:0] r_idx;
  assign w_sel  = r_idx;
  assign w_exam = 1'b1;
  assign w_last = (r_idx == IDX_W'(ACT_NUM-1));
`endif

  assign w_act_v  = r_acts[w_sel*ACT_WIDTH + 15];
  assign w_seg    = r_acts[w_sel*ACT_WIDTH + 8 +: 5];
  assign w_act_lo = r_acts[w_sel*ACT_WIDTH +: 8];
  assign w_seg_ok = ({1'b0, w_seg} < 6'(NUM_SEG));

  always_ff @(posedge clk) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (hdr_valid) w_next = S_ISSUE;
      S_ISSUE: if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_dcnt == 1'b0) w_next = S_OUT;
      S_OUT:   if (phv_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = (r_state == S_IDLE);
    phv_valid = (r_state == S_OUT);
    w_accept  = hdr_ready && hdr_valid;
    w_issue   = (r_state == S_ISSUE) && w_exam && w_act_v && w_seg_ok;
    w_bad     = (r_state == S_ISSUE) && w_exam && w_act_v && !w_seg_ok;
  end

  // r_drop masks a sub-parser result that lands in the cycle right after reset
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_hdr  <= '0;
      r_acts <= '0;
      r_dcnt <= 1'b0;
      r_drop <= 1'b1;
      r_phv  <= '0;
      r_err  <= 1'b0;
      r_sav  <= 1'b0;
      r_sa   <= '0;
      r_sph  <= '0;
`ifdef PARSE_SKIP_INVALID_EN
      r_pend <= '0;
`else
      r_idx  <= '0;
`endif
    end else begin
      r_drop <= 1'b0;
      r_sav  <= w_issue;
      if (w_issue) begin
        r_sa  <= w_act_lo;
        r_sph <= r_hdr[w_seg[SEG_W-1:0]*SUB_PKTS_LEN +: SUB_PKTS_LEN];
      end
      if (sub_val_valid && !r_drop) begin
        case (sub_val_type)
          2'b01:   r_phv[sub_val_seq*16 +: 16]       <= sub_val[15:0];
          2'b10:   r_phv[128 + sub_val_seq*32 +: 32] <= sub_val[31:0];
          2'b11:   r_phv[384 + sub_val_seq*64 +: 64] <= sub_val;
          default: ;
        endcase
      end
      if (w_bad) r_err <= 1'b1;
      if (r_state == S_ISSUE) begin
        r_dcnt <= 1'b1;
`ifdef PARSE_SKIP_INVALID_EN
        r_pend <= w_rest;
`else
        r_idx  <= r_idx + IDX_W'(1);
`endif
      end
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt - 1'b1;
      if (w_accept) begin
        r_hdr  <= pkt_hdr;
        r_acts <= parse_acts;
        r_phv  <= '0;
        r_err  <= 1'b0;
`ifdef PARSE_SKIP_INVALID_EN
        r_pend <= w_vmask;
`else
        r_idx  <= '0;
`endif
      end
    end
  end

  assign sub_act_valid = r_sav;
  assign sub_act       = r_sa;
  assign sub_pkts_hdr  = r_sph;
  assign phv_out       = r_phv;
  assign act_err       = r_err;
endmodule

// File: doc/parse_act_sched.md
PARSE_ACT_SCHED -- requirements
Module: parse_act_sched

Interface
REQ-001 SHALL have parameter ACT_NUM, default 8, number of parse actions per packet.
REQ-002 SHALL have parameter ACT_WIDTH, default 16, bits per parse action.
REQ-003 SHALL have parameter PKT_HDR_LEN, default 1024, captured header width in bits.
REQ-004 SHALL have parameter SUB_PKTS_LEN, default 128, segment width fed to the sub-parser.
REQ-005 SHALL have ports: clk input 1, clock; aresetn input 1, synchronous active-low reset.
REQ-006 SHALL have ports: hdr_valid input 1, header/action offer; hdr_ready output 1, accept; pkt_hdr input PKT_HDR_LEN, header; parse_acts input ACT_NUM*ACT_WIDTH, actions, entry i at [i*16 +: 16].
REQ-007 SHALL have ports: sub_act_valid output 1; sub_act output 8, action bits [7:0]; sub_pkts_hdr output SUB_PKTS_LEN, selected segment.
REQ-008 SHALL have sub-parser return ports: sub_val_valid input 1; sub_val input 64; sub_val_type input 2; sub_val_seq input 3.
REQ-009 SHALL have ports: phv_valid output 1; phv_ready input 1; phv_out output 896 = 8x16b [127:0], 8x32b [383:128], 8x64b [895:384], container k at its group base + k*width; act_err output 1, sticky per packet.

Function
REQ-010 Action format: [15] valid, [12:8] segment index, [7:5] byte in segment, [4:2] container seq, [1:0] type (01 2B, 10 4B, 11 8B).
REQ-011 FSM states IDLE, ISSUE, DRAIN, OUT; hdr_ready SHALL be 1 only in IDLE.
REQ-012 IDLE: on hdr_valid, register pkt_hdr and parse_acts, clear phv_out and act_err, zero index, go to ISSUE.
REQ-013 ISSUE: examine one action per cycle at the current index; if [15]=1 and segment < PKT_HDR_LEN/SUB_PKTS_LEN, registered outputs drive sub_act_valid=1, sub_act=act[7:0], sub_pkts_hdr=hdr[seg*SUB_PKTS_LEN +: SUB_PKTS_LEN] next cycle.
REQ-014 Invalid action ([15]=0) SHALL issue nothing; valid action with out-of-range segment SHALL issue nothing and set act_err.
REQ-015 After the action at index ACT_NUM-1 is examined, go to DRAIN; DRAIN lasts 2 cycles to absorb the 1-cycle sub-parser latency, then go to OUT.
REQ-016 Any cycle, sub_val_valid=1 SHALL write sub_val low bits into container sub_val_seq of the group selected by sub_val_type; type 00 ignored; repeated writes to same container: last wins.
REQ-017 OUT: phv_valid=1, phv_out and act_err stable until phv_ready=1; on that cycle go to IDLE, phv_valid=0 next cycle.
REQ-018 hdr_valid outside IDLE SHALL be ignored; back-to-back packets incur one IDLE cycle minimum.
REQ-019 Latency without skip: hdr accept to phv_valid = ACT_NUM+3 cycles.

Reset
REQ-020 aresetn=0 at a clock edge SHALL force IDLE; hdr_ready=1 after reset; sub_act_valid, phv_valid, act_err, sub_act, sub_pkts_hdr, phv_out SHALL be 0.
REQ-021 Reset mid-ISSUE/DRAIN/OUT SHALL discard the packet; results arriving in the following cycle SHALL be ignored.

Configuration
REQ-022 Macro PARSE_SKIP_INVALID_EN: when defined, ISSUE SHALL priority-select the next action with [15]=1 at or after the index, issuing one valid action per cycle with no bubbles; go to DRAIN once none remain (zero valid actions: ISSUE 1 cycle). When undefined, REQ-013/REQ-015 fixed ACT_NUM-cycle scan applies.

Verification
REQ-023 Action0=0x8121 (seg1, byte1, seq0, 2B), hdr seg1 bytes1-2 = 0xBEEF (with sub_parser) -> phv_out[15:0]=0xBEEF, other containers 0, phv_valid at cycle 11.
REQ-024 All 8 actions valid 8B, seq 0-7, seg 0-7 -> 8 consecutive sub_act_valid pulses, all 64b containers filled, act_err=0.
REQ-025 Action seg 8 with PKT_HDR_LEN=1024 -> no issue for it, act_err=1, remaining actions processed.
REQ-026 phv_ready held 0 for 5 cycles in OUT -> phv_valid/phv_out stable; hdr_valid asserted meanwhile -> hdr_ready=0, not accepted.
REQ-027 aresetn pulsed 0 during ISSUE index 3 -> all outputs 0 next cycle, next packet's phv_out contains no stale values.
REQ-028 With PARSE_SKIP_INVALID_EN, only actions 2 and 6 valid -> exactly 2 consecutive issue cycles, phv_valid 5 cycles after accept.
